// File: rtl/frame_pkg.sv
// Shared constants, state encoding and helpers for the frame dispatch path.
package frame_pkg;

    localparam int unsigned DW     = 16;
    localparam int unsigned MAXW   = 8;
    localparam int unsigned SER_W  = DW * MAXW;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned STAT_W = 16;

    // Descriptor layout: [15:8] channel, [7:3] reserved, [2:0] word count minus one
    localparam int unsigned CH_LSB = 8;
    localparam int unsigned NM1_W  = 3;

    localparam logic [31:0] HEADER  = 32'hE0E0E0E0;
    localparam logic [31:0] TRAILER = 32'h0E0E0E0E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_GRAY,
        ST_LOAD,
        ST_DROP
    } dispatch_state_t;

    function automatic logic is_onehot(input logic [CH_W-1:0] v);
        return (v != '0) && ((v & (v - CH_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/gray_enc128.sv
// Combinational binary-to-Gray encoder over the full serializer word.
module gray_enc128
    import frame_pkg::*;
(
    input  logic [SER_W-1:0] b,
    output logic [SER_W-1:0] g
);

    assign g = b ^ (b >> 1);

endmodule

// File: rtl/frame_dispatch_ctrl.sv
// Pops frame records from the FIFO, reassembles and Gray-codes the payload,
// and loads it into the serializer; frames with a bad channel are dropped.
module frame_dispatch_ctrl
    import frame_pkg::*;
(
    input  logic              clk_out,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DW-1:0]     fifo_rdata,
    input  logic              ser_busy,
    output logic              ser_load,
    output logic [SER_W-1:0]  ser_data,
    output logic [LEN_W-1:0]  ser_len,
    output logic [CH_W-1:0]   ser_ch,
    output logic              busy,
    output logic              drop_pulse,
    output logic [STAT_W-1:0] frame_cnt,
    output logic [STAT_W-1:0] drop_cnt
);

    dispatch_state_t   state_q, state_d;
    logic [CNT_W-1:0]  nwords_q, nwords_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  rcvd_q, rcvd_d;
    logic [SER_W-1:0]  buf_q, buf_d;
    logic              drop_q, drop_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              pend_q, pend_d;
    logic [SER_W-1:0]  ser_data_q, ser_data_d;
    logic [LEN_W-1:0]  ser_len_q, ser_len_d;
    logic [CH_W-1:0]   ser_ch_q, ser_ch_d;
    logic [STAT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              busy_q, busy_d;
    logic              drop_pulse_q, drop_pulse_d;
    logic [SER_W-1:0]  gray_w;

    gray_enc128 u_gray (
        .b (buf_q),
        .g (gray_w)
    );

    // fifo_rd_en and ser_load react to same-cycle flags, so they stay combinational
    always_comb begin
        state_d      = state_q;
        nwords_d     = nwords_q;
        issued_d     = issued_q;
        rcvd_d       = rcvd_q;
        buf_d        = buf_q;
        drop_d       = drop_q;
        ch_d         = ch_q;
        pend_d       = 1'b0;
        ser_data_d   = ser_data_q;
        ser_len_d    = ser_len_q;
        ser_ch_d     = ser_ch_q;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        fifo_rd_en   = 1'b0;
        ser_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && !fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                ch_d       = fifo_rdata[CH_LSB +: CH_W];
                nwords_d   = CNT_W'(fifo_rdata[NM1_W-1:0]) + CNT_W'(1);
                drop_d     = !is_onehot(fifo_rdata[CH_LSB +: CH_W]);
                rcvd_d     = '0;
                buf_d      = '0;
                // Every frame carries at least one word, so the first read can go now
                fifo_rd_en = !fifo_empty;
                issued_d   = CNT_W'(fifo_rd_en);
                pend_d     = fifo_rd_en;
                state_d    = ST_PAY;
            end
            ST_PAY: begin
                fifo_rd_en = !fifo_empty && (issued_q < nwords_q);
                issued_d   = issued_q + CNT_W'(fifo_rd_en);
                pend_d     = fifo_rd_en;
                if (pend_q) begin
                    buf_d  = {buf_q[SER_W-DW-1:0], fifo_rdata};
                    rcvd_d = rcvd_q + CNT_W'(1);
                end
                if (rcvd_d == nwords_q) begin
                    state_d = drop_q ? ST_DROP : ST_GRAY;
                end
            end
            ST_GRAY: begin
                ser_data_d = gray_w;
                ser_len_d  = LEN_W'({nwords_q, 4'b0000});
                ser_ch_d   = ch_q;
                state_d    = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ser_busy) begin
                    ser_load    = 1'b1;
                    frame_cnt_d = frame_cnt_q + STAT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            ST_DROP: begin
                drop_cnt_d = drop_cnt_q + STAT_W'(1);
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d != ST_IDLE);
        drop_pulse_d = (state_d == ST_DROP);
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            nwords_q     <= '0;
            issued_q     <= '0;
            rcvd_q       <= '0;
            buf_q        <= '0;
            drop_q       <= 1'b0;
            ch_q         <= '0;
            pend_q       <= 1'b0;
            ser_data_q   <= '0;
            ser_len_q    <= '0;
            ser_ch_q     <= '0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            busy_q       <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            nwords_q     <= nwords_d;
            issued_q     <= issued_d;
            rcvd_q       <= rcvd_d;
            buf_q        <= buf_d;
            drop_q       <= drop_d;
            ch_q         <= ch_d;
            pend_q       <= pend_d;
            ser_data_q   <= ser_data_d;
            ser_len_q    <= ser_len_d;
            ser_ch_q     <= ser_ch_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            busy_q       <= busy_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    assign ser_data   = ser_data_q;
    assign ser_len    = ser_len_q;
    assign ser_ch     = ser_ch_q;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = busy_q;
    assign drop_pulse = drop_pulse_q;

endmodule

// File: doc/frame_dispatch_ctrl.md
# frame_dispatch_ctrl

Output-side frame dispatch controller in the `clk_out` domain. It pops CRC-qualified frame records from the synchronous-read side of the frame FIFO and reassembles each payload into a right-aligned 128-bit word. It then Gray-encodes the payload and loads it into the 8-channel serializer, holding the load until the serializer is idle. Frames whose channel field is not one-hot are consumed and dropped. Per-frame statistics are counted.

## Interface
- `DW`, 16: FIFO word width.
- `MAXW`, 8: maximum payload words per frame (8 × 16 = 128 bits).
- `clk_out` in 1: controller clock. One clock only; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous reset, active-low.
- `en` in 1: permits popping a new descriptor. Dropping it low never aborts a frame already in progress.
- `fifo_empty` in 1: FIFO read-side empty flag.
- `fifo_rd_en` out 1: pop request. Data appears on `fifo_rdata` exactly 1 cycle later.
- `fifo_rdata` in 16: FIFO read data.
- `ser_busy` in 1: serializer is shifting; a load is illegal while high.
- `ser_load` out 1: one-cycle pulse that loads the serializer.
- `ser_data` out 128: Gray-coded payload, right-aligned; bit `ser_len-1` is sent first.
- `ser_len` out 8: payload length in bits, 16..128, a multiple of 16.
- `ser_ch` out 8: one-hot target channel.
- `busy` out 1: high in every state except IDLE.
- `drop_pulse` out 1: one-cycle pulse when a frame is discarded.
- `frame_cnt` out 16: frames loaded into the serializer; wraps at 16'hFFFF→0.
- `drop_cnt` out 16: frames dropped; wraps the same way.

## Operation
- FIFO record format:
  - Descriptor word: `[15:8]` channel, `[7:3]` reserved and ignored, `[2:0]` N-1, where N is the payload word count (1..8).
  - The descriptor is followed by N payload words, most significant first.
- States:
  - IDLE: if `en && !fifo_empty`, pulse `fifo_rd_en` and go to HDR.
  - HDR: latch the descriptor from `fifo_rdata`. Set `nwords=N`, `issued=0`, `rcvd=0`, `buf=0`. Set `drop=1` if the channel is not exactly one-hot (0 or 2+ bits set). Go to PAY.
  - PAY:
    - Read issue: `fifo_rd_en = !fifo_empty && issued<nwords`.
    - Capture: each cycle following a read, `buf <= {buf[111:0], fifo_rdata}` and `rcvd++`.
    - Exit when `rcvd==nwords`: go to DROP if `drop`, else GRAY.
  - GRAY: register `ser_data <= buf ^ (buf>>1)`, `ser_len <= nwords*16`, and `ser_ch`. Go to LOAD.
  - LOAD: wait for `!ser_busy`. Then pulse `ser_load`, increment `frame_cnt`, and go to IDLE.
  - DROP: pulse `drop_pulse`, increment `drop_cnt`, and go to IDLE. `ser_*` outputs are unchanged.
- Arithmetic and width rules:
  - Gray encoding covers all 128 bits of the zero-extended buffer, so the payload MSB passes through unchanged.
  - `issued` and `rcvd` are 4 bits wide.
  - `ser_len` is `{nwords,4'b0}`.
- FIFO rules:
  - `fifo_rd_en` is never asserted while `fifo_empty` is high.
  - If the FIFO empties mid-frame, reads stall and the controller waits in PAY indefinitely.
- Serializer rules:
  - `ser_data`, `ser_len` and `ser_ch` hold from GRAY until the next GRAY.
  - The serializer samples them on `ser_load`.
- `en` low while in HDR, PAY, GRAY, LOAD or DROP has no effect. It is only checked in IDLE.

## Timing
- Reset values: state IDLE; all outputs 0, including `ser_data`, `ser_len`, `ser_ch`, the counters, `busy` and both pulses.
- Reset mid-frame returns to IDLE immediately. The FIFO shares `rst_n` and is flushed with it, so no partial record survives.
- Latency with the FIFO never empty and `ser_busy` low, counting from the cycle the descriptor `fifo_rd_en` is high (cycle 0):
  - Payload read pulses in cycles 1..N, back to back.
  - Last word captured at the end of cycle N+1.
  - GRAY in cycle N+2.
  - `ser_load` high in cycle N+3.
  - Earliest next descriptor pop in cycle N+4.
- Drop path: `drop_pulse` in cycle N+2; next pop no earlier than cycle N+3.
- `ser_busy` high in LOAD delays `ser_load` to the first cycle in which `ser_busy` is sampled low.
- `busy` is registered state decode; it is 0 only in IDLE.

## Structure
- Shared package `frame_pkg`:
  - `HEADER=32'hE0E0E0E0` and `TRAILER=32'h0E0E0E0E`.
  - State enum `dispatch_state_t`.
  - Descriptor field positions and the `MAXW`/`DW` constants.
  - One-hot check function.
- One sub-module: `gray_enc128`, combinational `g = b ^ (b>>1)`. It is reused by the bench reference model.
- Target size: roughly 150–250 lines of RTL.

## Test plan
- Descriptor 16'h0100, payload 16'hA55A, FIFO preloaded, `ser_busy`=0:
  - `ser_load` in cycle 4.
  - `ser_data`=128'hF7F7, `ser_len`=16, `ser_ch`=8'h01, `frame_cnt`=1.
- Descriptor 16'h0207, payload 0123_4567_89AB_CDEF_FEDC_BA98_7654_3210:
  - `ser_data` = that value ^ (value>>1).
  - `ser_len`=128, `ser_ch`=8'h02.
  - `ser_load` in cycle 11.
- Descriptor 16'h0301 followed by 2 words, then descriptor 16'h0400 + 16'h1234:
  - `drop_pulse` once and `drop_cnt`=1 for the first frame.
  - Second frame: `ser_data`=128'h1B2E, `ser_ch`=8'h04.
- Empty the FIFO after the descriptor plus 2 of 4 payload words, then refill 20 cycles later:
  - `fifo_rd_en` is never high while empty.
  - The frame completes correctly.
- Hold `ser_busy`=1 for 50 cycles in LOAD, and toggle `en`=0 mid-PAY:
  - `ser_load` fires in the first cycle after `ser_busy` falls.
  - No new descriptor is popped while `en`=0.
- Assert `rst_n`=0 in PAY:
  - All outputs return to 0 immediately; state is IDLE.
  - `frame_cnt`=0 after release.
